// File: rtl/noc.sv
// Shared NoC types plus the header layout and XY lookahead helper for local injection.
package noc;

    localparam int unsigned CoordWidth = 3;
    localparam int unsigned UserWidth  = 15;
    localparam int unsigned RouteWidth = 5;

    typedef logic [CoordWidth-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } xy_t;

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    // Header flit data field positions (LSB of each field).
    localparam int unsigned HdrSrcYLsb  = 29;
    localparam int unsigned HdrSrcXLsb  = 26;
    localparam int unsigned HdrDstYLsb  = 23;
    localparam int unsigned HdrDstXLsb  = 20;
    localparam int unsigned HdrRouteLsb = 15;
    localparam int unsigned HdrUserLsb  = 0;

    // Output-port one-hot encodings of the router.
    localparam logic [RouteWidth-1:0] kN = 5'b00001;
    localparam logic [RouteWidth-1:0] kS = 5'b00010;
    localparam logic [RouteWidth-1:0] kW = 5'b00100;
    localparam logic [RouteWidth-1:0] kE = 5'b01000;
    localparam logic [RouteWidth-1:0] kP = 5'b10000;

    // Dimension-ordered routing: resolve X first, then Y, else eject locally.
    function automatic logic [RouteWidth-1:0] xy_lookahead(xy_t pos, xy_t dst);
        logic [RouteWidth-1:0] route;
        route = kP;
        if (dst.x > pos.x) begin
            route = kE;
        end else if (dst.x < pos.x) begin
            route = kW;
        end else if (dst.y > pos.y) begin
            route = kS;
        end else if (dst.y < pos.y) begin
            route = kN;
        end
        return route;
    endfunction

endpackage

// File: rtl/lookahead_local_injector.sv
// Local network interface: frames descriptors and payload words into flits for the router P input.
module lookahead_local_injector
    import noc::*;
#(
    parameter int unsigned Width    = 34,
    parameter int unsigned LenWidth = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CoordWidth-1:0]                CONST_localx,
    input  logic [CoordWidth-1:0]                CONST_localy,
    input  logic                                 pkt_valid,
    output logic                                 pkt_ready,
    input  logic [CoordWidth-1:0]                pkt_dst_x,
    input  logic [CoordWidth-1:0]                pkt_dst_y,
    input  logic [UserWidth-1:0]                 pkt_user,
    input  logic [LenWidth-1:0]                  pkt_len,
    input  logic                                 pay_valid,
    output logic                                 pay_ready,
    input  logic [Width-$bits(preamble_t)-1:0]   pay_data,
    output logic [Width-1:0]                     data_out,
    output logic                                 data_void_out,
    input  logic                                 stop_in
);

    localparam int unsigned DataWidth = Width - $bits(preamble_t);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAD    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [LenWidth-1:0]    remaining_q;
    logic [LenWidth-1:0]    remaining_d;
    xy_t                    dst_q;
    logic [UserWidth-1:0]   user_q;
    logic [LenWidth-1:0]    len_q;
    logic                   latch;
    logic                   load;
    logic [Width-1:0]       flit_d;
    logic [DataWidth-1:0]   hdr;
    xy_t                    pos;
    preamble_t              pre;

    // Next-state, flit formation and payload handshake.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        latch       = 1'b0;
        load        = 1'b0;
        flit_d      = '0;
        pay_ready   = 1'b0;
        pre         = '0;
        pos         = '{x: CONST_localx, y: CONST_localy};

        hdr                                 = '0;
        hdr[HdrSrcYLsb  +: CoordWidth]      = CONST_localy;
        hdr[HdrSrcXLsb  +: CoordWidth]      = CONST_localx;
        hdr[HdrDstYLsb  +: CoordWidth]      = dst_q.y;
        hdr[HdrDstXLsb  +: CoordWidth]      = dst_q.x;
        hdr[HdrRouteLsb +: RouteWidth]      = xy_lookahead(pos, dst_q);
        hdr[HdrUserLsb  +: UserWidth]       = user_q;

        case (state_q)
            IDLE: begin
                if (pkt_valid && pkt_ready) begin
                    latch   = 1'b1;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (!stop_in) begin
                    load     = 1'b1;
                    pre.head = 1'b1;
                    pre.tail = (len_q == '0);
                    flit_d   = {pre, hdr};
                    if (len_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        remaining_d = len_q;
                        state_d     = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                pay_ready = !stop_in;
                if (pay_valid && !stop_in) begin
                    load        = 1'b1;
                    pre.tail    = (remaining_q == LenWidth'(1));
                    flit_d      = {pre, pay_data};
                    remaining_d = remaining_q - LenWidth'(1);
                    if (remaining_q == LenWidth'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, descriptor latch and output flit register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            dst_q         <= '0;
            user_q        <= '0;
            len_q         <= '0;
            data_out      <= '0;
            data_void_out <= 1'b1;
            pkt_ready     <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            data_void_out <= !load;
            pkt_ready     <= (state_d == IDLE);
            if (latch) begin
                dst_q  <= '{x: pkt_dst_x, y: pkt_dst_y};
                user_q <= pkt_user;
                len_q  <= pkt_len;
            end
            if (load) begin
                data_out <= flit_d;
            end
        end
    end

endmodule

// File: tb/tb_lookahead_local_injector.sv
// Directed bench for the local injector with an expected-flit scoreboard.
module tb_lookahead_local_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  CONST_localx;
    logic [2:0]  CONST_localy;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [2:0]  pkt_dst_x;
    logic [2:0]  pkt_dst_y;
    logic [14:0] pkt_user;
    logic [3:0]  pkt_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [31:0] pay_data;
    logic [33:0] data_out;
    logic        data_void_out;
    logic        stop_in;

    logic [33:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          flits = 0;

    always #5 clk = ~clk;

    lookahead_local_injector #(.Width(34), .LenWidth(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .CONST_localx  (CONST_localx),
        .CONST_localy  (CONST_localy),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .pkt_dst_x     (pkt_dst_x),
        .pkt_dst_y     (pkt_dst_y),
        .pkt_user      (pkt_user),
        .pkt_len       (pkt_len),
        .pay_valid     (pay_valid),
        .pay_ready     (pay_ready),
        .pay_data      (pay_data),
        .data_out      (data_out),
        .data_void_out (data_void_out),
        .stop_in       (stop_in)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] hdr_flit(input int px, input int py, input int dx, input int dy,
                                             input logic [4:0] route, input logic [14:0] user,
                                             input int len);
        logic tail;
        tail = (len == 0);
        return {1'b1, tail, 3'(py), 3'(px), 3'(dy), 3'(dx), route, user};
    endfunction

    // Every non-void flit must match the oldest expected one.
    always @(negedge clk) begin
        if (data_void_out === 1'b0) begin
            flits++;
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_flit observed=%0h expected=none", data_out);
            end
            if (sb.size() != 0) begin
                n_cmp--;
                check("flit", 64'(data_out), 64'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input int px, input int py, input int dx, input int dy,
                             input logic [4:0] route, input logic [14:0] user, input int len);
        int   cnt;
        logic r;
        CONST_localx = 3'(px);
        CONST_localy = 3'(py);
        pkt_dst_x    = 3'(dx);
        pkt_dst_y    = 3'(dy);
        pkt_user     = user;
        pkt_len      = 4'(len);
        pkt_valid    = 1'b1;
        sb.push_back(hdr_flit(px, py, dx, dy, route, user, len));
        cnt = 0;
        r   = 1'b0;
        while (!r && cnt < 50) begin
            @(negedge clk);
            r = pkt_ready;
            tick();
            cnt++;
        end
        pkt_valid = 1'b0;
        check("pkt_accept", 64'(r), 64'(1));
    endtask

    task automatic send_word(input logic [31:0] data, input logic tail);
        int   cnt;
        logic r;
        pay_valid = 1'b1;
        pay_data  = data;
        sb.push_back({1'b0, tail, data});
        cnt = 0;
        r   = 1'b0;
        while (!r && cnt < 50) begin
            @(negedge clk);
            r = pay_ready;
            tick();
            cnt++;
        end
        pay_valid = 1'b0;
        check("pay_accept", 64'(r), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        int base;

        // Reset held with a descriptor already offered.
        rst          = 1'b0;
        stop_in      = 1'b0;
        pay_valid    = 1'b0;
        pay_data     = '0;
        CONST_localx = 3'd2;
        CONST_localy = 3'd2;
        pkt_dst_x    = 3'd2;
        pkt_dst_y    = 3'd2;
        pkt_user     = 15'h1234;
        pkt_len      = 4'd0;
        pkt_valid    = 1'b1;
        sb.push_back(hdr_flit(2, 2, 2, 2, 5'b10000, 15'h1234, 0));
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_void", 64'(data_void_out), 64'(1));
            check("rst_pkt_ready", 64'(pkt_ready), 64'(0));
            check("rst_pay_ready", 64'(pay_ready), 64'(0));
        end
        check("rst_data", 64'(data_out), 64'(0));
        tick();
        rst = 1'b1;

        // Single-flit self-addressed packet; measure latency from reset release.
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (data_void_out === 1'b0) break;
        end
        pkt_valid = 1'b0;
        check("reset_latency_ok", 64'(lat >= 2 && lat < 20), 64'(1));
        @(posedge clk);
        @(negedge clk);
        check("idle_after_single", 64'(pkt_ready), 64'(1));
        check("void_after_single", 64'(data_void_out), 64'(1));
        tick();

        // Multi-flit packet heading east.
        send_desc(1, 3, 4, 0, 5'b01000, 15'h0abc, 3);
        send_word(32'hAAAA_0001, 1'b0);
        send_word(32'hBBBB_0002, 1'b0);
        send_word(32'hCCCC_0003, 1'b1);
        repeat (3) tick();

        // Routing sweep from (3,3).
        send_desc(3, 3, 0, 3, 5'b00100, 15'h0001, 0);
        send_desc(3, 3, 3, 0, 5'b00001, 15'h0002, 0);
        send_desc(3, 3, 3, 7, 5'b00010, 15'h0003, 0);
        send_desc(3, 3, 7, 7, 5'b01000, 15'h0004, 1);
        send_word(32'h1357_9bdf, 1'b1);
        repeat (3) tick();

        // Backpressure in the middle of the payload.
        base = flits;
        send_desc(0, 0, 0, 4, 5'b00010, 15'h7fff, 4);
        send_word(32'h0000_0010, 1'b0);
        send_word(32'h0000_0011, 1'b0);
        stop_in   = 1'b1;
        pay_valid = 1'b1;
        pay_data  = 32'h0000_0012;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_pay_ready", 64'(pay_ready), 64'(0));
            if (k > 0) check("bp_void", 64'(data_void_out), 64'(1));
            tick();
        end
        stop_in = 1'b0;
        send_word(32'h0000_0012, 1'b0);
        send_word(32'h0000_0013, 1'b1);
        repeat (3) tick();
        check("bp_flit_count", 64'(flits - base), 64'(5));

        // Reset after two of five payload words.
        send_desc(1, 1, 0, 1, 5'b00100, 15'h0055, 5);
        send_word(32'hDEAD_0000, 1'b0);
        send_word(32'hDEAD_0001, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_void", 64'(data_void_out), 64'(1));
        check("midrst_pay_ready", 64'(pay_ready), 64'(0));
        check("midrst_sb_empty", 64'(sb.size()), 64'(0));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_idle_pay_ready", 64'(pay_ready), 64'(0));
        tick();
        @(negedge clk);
        check("midrst_idle_pkt_ready", 64'(pkt_ready), 64'(1));
        tick();

        // Next packet after the truncated one.
        send_desc(2, 2, 5, 2, 5'b01000, 15'h0123, 1);
        send_word(32'hFEED_BEEF, 1'b1);
        repeat (4) tick();
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
